// File: rtl/mult_unit.sv
// mult_unit: iterative radix-2 shift-add multiplier for the EX stage.
// Produces a 2*WIDTH product into HI/LO, with mthi/mtlo writes and flush.
module mult_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signd,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    logic               busy_nx;
    logic               done_nx;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign accept = start & ~flush;
    assign last   = (cnt == CNTW'(WIDTH - 1));
    assign addend = mplier[0] ? mcand : {WIDTH{1'b0}};
    assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    assign result = neg ? -acc : acc;
    // Magnitudes; the most negative value maps onto itself as unsigned.
    assign abs_a  = (signd & srca[WIDTH-1]) ? -srca : srca;
    assign abs_b  = (signd & srcb[WIDTH-1]) ? -srcb : srcb;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN: begin
                if (flush)     state_nx = IDLE;
                else if (last) state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
        unique case (state)
            IDLE:    busy_nx = accept;
            RUN:     busy_nx = ~flush;
            FIX:     done_nx = ~flush;
            default: busy_nx = 1'b0;
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nx;
            done <= done_nx;
        end
    end

    // Operand latch, shift-add datapath and iteration counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                mcand  <= abs_a;
                mplier <= abs_b;
                neg    <= signd & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                acc    <= '0;
                cnt    <= '0;
            end
        end else if (state == RUN) begin
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CNTW'(1);
        end
    end

    // HI/LO: mthi/mtlo only while idle, product on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == IDLE) begin
            if (hiwe) hi <= wdata;
            if (lowe) lo <= wdata;
        end else if (state == FIX && !flush) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: randomized and directed checks of mult_unit
// against a plain-arithmetic product model.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signd;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        hiwe;
    logic        lowe;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int tests  = 0;
    int errors = 0;

    mult_unit #(.WIDTH(32), .CNTW(6)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .signd  (signd),
        .srca   (srca),
        .srcb   (srcb),
        .flush  (flush),
        .hiwe   (hiwe),
        .lowe   (lowe),
        .wdata  (wdata),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic s);
        longint sa;
        longint sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (s) return 64'(sa * sb);
        return ua * ub;
    endfunction

    // Runs one multiply; optionally pokes a start and an mthi at
    // cycle 'poke' while busy, both of which must be ignored.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input int poke,
                            input string tag);
        logic [63:0] exp;
        int lat;
        int bc;
        exp   = ref_prod(a, b, s);
        start = 1'b1;
        signd = s;
        srca  = a;
        srcb  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bc    = 0;
        while (!done && lat < 60) begin
            if (busy) bc++;
            if (lat == poke) begin
                start = 1'b1;
                signd = ~s;
                srca  = ~a;
                srcb  = b + 32'd1;
                hiwe  = 1'b1;
                wdata = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
                hiwe  = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        hiwe  = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_busy"}, 64'(bc), 64'd33);
        chk({tag, "_prod"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          seen;
        reset_n = 1'b0;
        start   = 1'b0;
        signd   = 1'b0;
        srca    = '0;
        srcb    = '0;
        flush   = 1'b0;
        hiwe    = 1'b0;
        lowe    = 1'b0;
        wdata   = '0;
        #12;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, "umax");
        chk("umax_hl", {hi, lo}, 64'hFFFFFFFE_00000001);
        run_mult(32'hFFFFFFFD, 32'd5, 1'b1, -1, "smix");
        chk("smix_hl", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        run_mult(32'hFFFFFFFD, 32'd5, 1'b0, -1, "umix");
        chk("umix_hl", {hi, lo}, 64'h00000004_FFFFFFF1);
        run_mult(32'h80000000, 32'h80000000, 1'b1, -1, "smin");
        chk("smin_hl", {hi, lo}, 64'h40000000_00000000);
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, -1, "sm1");
        chk("sm1_hl", {hi, lo}, 64'h00000000_00000001);
        run_mult(32'h12345678, 32'h9ABCDEF0, 1'b1, 6, "poke");

        // mthi/mtlo preload, then flush a 7*9 multiply mid-run.
        @(posedge clk);
        #1;
        hiwe  = 1'b1;
        wdata = 32'h11111111;
        @(posedge clk);
        #1;
        hiwe  = 1'b0;
        lowe  = 1'b1;
        wdata = 32'h22222222;
        @(posedge clk);
        #1;
        lowe  = 1'b0;
        chk("preload", {hi, lo}, 64'h11111111_22222222);
        start = 1'b1;
        signd = 1'b0;
        srca  = 32'd7;
        srcb  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        chk("flush_done", 64'(seen), 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h11111111_22222222);

        // mtlo together with start: write lands, multiply still runs.
        lowe  = 1'b1;
        wdata = 32'hCAFEF00D;
        start = 1'b1;
        signd = 1'b0;
        srca  = 32'd100;
        srcb  = 32'd3;
        @(posedge clk);
        #1;
        lowe  = 1'b0;
        start = 1'b0;
        chk("mtlo_start", {31'd0, busy, lo}, {31'd0, 1'b1, 32'hCAFEF00D});
        seen = 0;
        while (!done && seen < 60) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("mtlo_prod", {hi, lo}, 64'd300);

        // Randomized multiplies issued back-to-back on the done cycle.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 5 == 1) ra = 32'h80000000;
            if (i % 7 == 2) rb = 32'd0;
            run_mult(ra, rb, rs, (i % 3 == 0) ? int'($urandom_range(0, 31))
                                              : -1, "rnd");
        end

        // Asynchronous reset between edges in the middle of a run.
        start = 1'b1;
        signd = 1'b1;
        srca  = 32'hFFFF0000;
        srcb  = 32'h00001234;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_mult(32'd2, 32'd3, 1'b0, -1, "post_rst");
        chk("post_rst_hl", {hi, lo}, 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
